// File: rtl/or1k_spr_initiator_pkg.sv
// Shared definitions for the OR1K SPR bus initiator: FSM encodings,
// the default access timeout and the SPR address field layout.
package or1k_spr_initiator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } spr_state_e;

    localparam int DEFAULT_TIMEOUT = 16;

    // SPR address is {group[15:11], offset[10:0]}
    localparam int SPR_GROUP_MSB  = 15;
    localparam int SPR_GROUP_LSB  = 11;
    localparam int SPR_OFFSET_MSB = 10;
    localparam int SPR_OFFSET_LSB = 0;

endpackage

// File: rtl/or1k_spr_initiator.sv
// Bridges a core valid/ready request onto the SPR bus, waits for the
// responder ack (or a timeout) and returns the result on a valid/ready response.
module or1k_spr_initiator
    import or1k_spr_initiator_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [15:0] req_addr_i,
    input  logic [31:0] req_dat_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    output logic        spr_access_o,
    output logic        spr_we_o,
    output logic [15:0] spr_addr_o,
    output logic [31:0] spr_dat_o,
    input  logic        spr_bus_ack_i,
    input  logic [31:0] spr_dat_i
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    spr_state_e  state_q;
    spr_state_e  state_d;
    logic [7:0]  cnt_q;
    logic [7:0]  cnt_inc;
    logic        timeout_hit;
    logic        we_q;
    logic [15:0] addr_q;
    logic [31:0] dat_q;
    logic [31:0] rsp_dat_q;
    logic        rsp_err_q;

    assign cnt_inc     = cnt_q + 8'd1;
    assign timeout_hit = (cnt_inc == TIMEOUT_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request fields only load in IDLE, so they stay frozen through ACCESS and RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= 8'd0;
            we_q      <= 1'b0;
            addr_q    <= 16'd0;
            dat_q     <= 32'd0;
            rsp_dat_q <= 32'd0;
            rsp_err_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        we_q   <= req_we_i;
                        addr_q <= req_addr_i;
                        dat_q  <= req_dat_i;
                        cnt_q  <= 8'd0;
                    end
                end
                ST_ACCESS: begin
                    if (spr_bus_ack_i) begin
                        rsp_dat_q <= we_q ? 32'd0 : spr_dat_i;
                        rsp_err_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_inc;
                        if (timeout_hit) begin
                            rsp_dat_q <= 32'd0;
                            rsp_err_q <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Ack is tested before the timeout so a same-cycle collision completes cleanly.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (spr_bus_ack_i || timeout_hit) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o  = 1'b0;
        rsp_valid_o  = 1'b0;
        rsp_dat_o    = 32'd0;
        rsp_err_o    = 1'b0;
        spr_access_o = 1'b0;
        spr_we_o     = 1'b0;
        spr_addr_o   = 16'd0;
        spr_dat_o    = 32'd0;
        case (state_q)
            ST_IDLE: begin
                req_ready_o = 1'b1;
            end
            ST_ACCESS: begin
                spr_access_o = 1'b1;
                spr_we_o     = we_q;
                spr_addr_o   = addr_q;
                spr_dat_o    = we_q ? dat_q : 32'd0;
            end
            ST_RESP: begin
                rsp_valid_o = 1'b1;
                rsp_dat_o   = rsp_dat_q;
                rsp_err_o   = rsp_err_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_or1k_spr_initiator.sv
// Directed scoreboard bench for or1k_spr_initiator: reads, writes, timeout,
// ack/timeout collision, response backpressure and reset during an access.
module tb_or1k_spr_initiator;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [15:0] req_addr_i = 16'd0;
    logic [31:0] req_dat_i = 32'd0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b1;
    logic [31:0] rsp_dat_o;
    logic        rsp_err_o;
    logic        spr_access_o;
    logic        spr_we_o;
    logic [15:0] spr_addr_o;
    logic [31:0] spr_dat_o;
    logic        spr_bus_ack_i;
    logic [31:0] spr_dat_i;

    typedef struct packed {
        logic [31:0] dat;
        logic        err;
    } rsp_t;

    rsp_t        expected_q[$];
    int          checks = 0;
    int          failures = 0;

    logic        ack_on = 1'b1;
    int          ack_at = 0;
    logic [31:0] resp_data = 32'd0;
    int          access_cnt = 0;

    or1k_spr_initiator #(.TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_addr_i   (req_addr_i),
        .req_dat_i    (req_dat_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_dat_o    (rsp_dat_o),
        .rsp_err_o    (rsp_err_o),
        .spr_access_o (spr_access_o),
        .spr_we_o     (spr_we_o),
        .spr_addr_o   (spr_addr_o),
        .spr_dat_o    (spr_dat_o),
        .spr_bus_ack_i(spr_bus_ack_i),
        .spr_dat_i    (spr_dat_i)
    );

    always #5 clk = ~clk;

    // Responder acks combinationally on the ack_at-th cycle (0-based) of an access.
    always @(posedge clk) access_cnt <= spr_access_o ? access_cnt + 1 : 0;
    assign spr_bus_ack_i = spr_access_o && ack_on && (access_cnt == ack_at);
    assign spr_dat_i     = resp_data;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [15:0] addr, input logic [31:0] dat,
                                 input logic [31:0] exp_dat, input logic exp_err);
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = addr;
        req_dat_i   = dat;
        expected_q.push_back('{dat: exp_dat, err: exp_err});
    endtask

    task automatic popResponse(input string tag);
        rsp_t exp;
        if (expected_q.size() == 0) begin
            checks++;
            failures++;
            $error("[TB] FAIL %s observed=response expected=empty_scoreboard", tag);
        end else begin
            exp = expected_q.pop_front();
            checkOutput({tag, "_valid"}, rsp_valid_o, 1'b1);
            checkOutput({tag, "_dat"}, rsp_dat_o, exp.dat);
            checkOutput({tag, "_err"}, rsp_err_o, exp.err);
        end
    endtask

    task automatic waitAccessEnd(input int max_cycles, output int n);
        n = 0;
        while (spr_access_o && n < max_cycles) begin
            n++;
            tick();
        end
    endtask

    initial begin
        int n;
        int valid_seen;

        repeat (2) tick();
        checkOutput("reset_req_ready", req_ready_o, 1'b1);
        checkOutput("reset_rsp_valid", rsp_valid_o, 1'b0);
        checkOutput("reset_rsp_err", rsp_err_o, 1'b0);
        checkOutput("reset_spr_access", spr_access_o, 1'b0);
        checkOutput("reset_spr_we", spr_we_o, 1'b0);
        checkOutput("reset_spr_addr", spr_addr_o, 32'd0);
        checkOutput("reset_spr_dat", spr_dat_o, 32'd0);
        rst_n = 1'b1;
        tick();

        $display("[TB] zero-wait read");
        ack_on = 1'b1; ack_at = 0; resp_data = 32'hDEADBEEF; rsp_ready_i = 1'b1;
        applyStimulus(1'b0, 16'h5000, 32'h1111_2222, 32'hDEADBEEF, 1'b0);
        tick();
        req_valid_i = 1'b0; req_we_i = 1'b1; req_addr_i = 16'hFFFF;
        checkOutput("rd_access", spr_access_o, 1'b1);
        checkOutput("rd_addr", spr_addr_o, 32'h5000);
        checkOutput("rd_we", spr_we_o, 1'b0);
        checkOutput("rd_spr_dat", spr_dat_o, 32'd0);
        checkOutput("rd_req_ready", req_ready_o, 1'b0);
        checkOutput("rd_early_valid", rsp_valid_o, 1'b0);
        waitAccessEnd(20, n);
        checkOutput("rd_access_cycles", n, 32'd1);
        popResponse("rd_rsp");
        tick();
        checkOutput("rd_retired", rsp_valid_o, 1'b0);
        checkOutput("rd_idle_ready", req_ready_o, 1'b1);

        $display("[TB] write");
        resp_data = 32'h9999_9999;
        applyStimulus(1'b1, 16'h5001, 32'h12345678, 32'd0, 1'b0);
        tick();
        req_valid_i = 1'b0; req_dat_i = 32'h0;
        checkOutput("wr_access", spr_access_o, 1'b1);
        checkOutput("wr_we", spr_we_o, 1'b1);
        checkOutput("wr_addr", spr_addr_o, 32'h5001);
        checkOutput("wr_spr_dat", spr_dat_o, 32'h12345678);
        waitAccessEnd(20, n);
        checkOutput("wr_access_cycles", n, 32'd1);
        popResponse("wr_rsp");
        tick();

        $display("[TB] timeout");
        ack_on = 1'b0; resp_data = 32'h7777_7777;
        applyStimulus(1'b0, 16'h0810, 32'd0, 32'd0, 1'b1);
        tick();
        req_valid_i = 1'b0;
        waitAccessEnd(20, n);
        checkOutput("to_access_cycles", n, TIMEOUT);
        popResponse("to_rsp");
        tick();

        $display("[TB] ack/timeout collision");
        ack_on = 1'b1; ack_at = TIMEOUT - 1; resp_data = 32'hCAFEF00D;
        applyStimulus(1'b0, 16'h0811, 32'd0, 32'hCAFEF00D, 1'b0);
        tick();
        req_valid_i = 1'b0;
        waitAccessEnd(20, n);
        checkOutput("col_access_cycles", n, TIMEOUT);
        popResponse("col_rsp");
        tick();

        $display("[TB] backpressure");
        ack_at = 1; resp_data = 32'hA5A5_5A5A; rsp_ready_i = 1'b0;
        applyStimulus(1'b0, 16'h2800, 32'd0, 32'hA5A5_5A5A, 1'b0);
        tick();
        req_valid_i = 1'b0;
        waitAccessEnd(20, n);
        checkOutput("bp_access_cycles", n, 32'd2);
        applyStimulus(1'b1, 16'h0011, 32'h0BADCAFE, 32'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_hold_valid", rsp_valid_o, 1'b1);
            checkOutput("bp_hold_dat", rsp_dat_o, 32'hA5A5_5A5A);
            checkOutput("bp_hold_err", rsp_err_o, 1'b0);
            checkOutput("bp_hold_req_ready", req_ready_o, 1'b0);
            checkOutput("bp_hold_no_access", spr_access_o, 1'b0);
            tick();
        end
        popResponse("bp_rsp");
        rsp_ready_i = 1'b1;
        tick();
        checkOutput("bp_retire_ready", req_ready_o, 1'b1);
        checkOutput("bp_retire_no_access", spr_access_o, 1'b0);
        checkOutput("bp_retire_valid", rsp_valid_o, 1'b0);
        tick();
        req_valid_i = 1'b0;
        checkOutput("bp_next_access", spr_access_o, 1'b1);
        checkOutput("bp_next_addr", spr_addr_o, 32'h0011);
        checkOutput("bp_next_we", spr_we_o, 1'b1);
        checkOutput("bp_next_dat", spr_dat_o, 32'h0BADCAFE);
        waitAccessEnd(20, n);
        checkOutput("bp_next_access_cycles", n, 32'd2);
        popResponse("bp_next_rsp");
        tick();

        $display("[TB] reset mid-access");
        ack_on = 1'b0;
        req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 16'h3000;
        tick();
        req_valid_i = 1'b0;
        checkOutput("rst_pre_access", spr_access_o, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async_access", spr_access_o, 1'b0);
        checkOutput("rst_async_addr", spr_addr_o, 32'd0);
        checkOutput("rst_async_ready", req_ready_o, 1'b1);
        repeat (2) tick();
        rst_n = 1'b1;
        valid_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rsp_valid_o !== 1'b0) valid_seen++;
        end
        checkOutput("rst_no_response", valid_seen, 32'd0);
        checkOutput("scoreboard_empty", expected_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
